memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter: DATA_WIDTH, 16, word width in bits.
REQ-002 Parameter: ADDR_WIDTH, 16, address width in bits; depth SHALL be 2^ADDR_WIDTH words.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: data  input  DATA_WIDTH  write data.
REQ-006 Port: addr  input  ADDR_WIDTH  word address for read and write.
REQ-007 Port: we  input  1  write enable, active-high, sampled on the rising clk edge.
REQ-008 Port: q  output  DATA_WIDTH  registered read data.

Function
REQ-009 The block SHALL be a single-port synchronous RAM of 2^ADDR_WIDTH words of DATA_WIDTH bits, word-addressed, with no byte enables.
REQ-010 At each rising clk edge with reset low and we=1, mem[addr] SHALL be loaded with data.
REQ-011 At each rising clk edge with reset low and we=1, q SHALL be loaded with data (write-first / read-through).
REQ-012 At each rising clk edge with reset low and we=0, q SHALL be loaded with mem[addr] and memory SHALL be unchanged.
REQ-013 Read latency SHALL be exactly one clock: q reflects the address and data presented before the sampling edge and holds until the next edge.
REQ-014 q SHALL NOT change combinationally with addr, data or we.
REQ-015 Every address 0 to 2^ADDR_WIDTH-1 SHALL be accessible; there is no wrap, aliasing or out-of-range condition.
REQ-016 Back-to-back writes to different addresses on consecutive edges SHALL each complete with no stall.
REQ-017 A write followed immediately by a read of the same address on the next edge SHALL return the newly written value.
REQ-018 X or Z on we SHALL be treated as no write.
REQ-019 Power-up contents: mem[0]=0x0000, mem[1]=0xB024, mem[2]=0xB0C3; all other words SHALL be 0x0000.
REQ-020 The power-up contents SHALL be set by initialization only and SHALL NOT be enforced by reset.

Reset
REQ-021 While reset is high, q SHALL be 0x0000 immediately, without waiting for a clock edge.
REQ-022 While reset is high, writes SHALL be suppressed.
REQ-023 Reset SHALL NOT alter memory contents; previously written words SHALL survive reset.
REQ-024 After reset deasserts, the first rising edge SHALL perform a normal read or write per REQ-010 to REQ-012.
REQ-025 Reset asserted mid-operation SHALL abort any write not yet clocked; a write clocked before reset rose SHALL be retained.

Verification
REQ-026 Read initial word: reset low, we=0, addr=0x0001, one clk -> q=0xB024.
REQ-027 Read initial word: we=0, addr=0x0002, one clk -> q=0xB0C3.
REQ-028 Write-through: we=1, addr=0x0003, data=0xBC48, one clk -> q=0xBC48 at that same edge.
REQ-029 Persistence: we=0, addr=0x0002, one clk -> q=0xB0C3; then addr=0x0003, one clk -> q=0xBC48.
REQ-030 Reset: assert reset between edges -> q=0x0000 at once; with we=1 and data=0x1234 at addr 0x0003 while reset is high, clk edges -> no write; deassert reset, we=0, addr=0x0003, one clk -> q=0xBC48.
REQ-031 Boundaries: write 0xFFFF to 0xFFFF and 0xA5A5 to 0x0000 on consecutive edges; read both -> 0xFFFF and 0xA5A5, with no aliasing.

Source files
------------

// File: rtl/memory.sv
// Single-port synchronous RAM with write-first read-through and a registered output.
// Power-up contents come from the array initializer; reset clears only the output register.
module memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Image loaded at configuration time; reset deliberately leaves it alone.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{
    0:       '0,
    1:       DATA_WIDTH'(16'hB024),
    2:       DATA_WIDTH'(16'hB0C3),
    default: '0
  };

  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  wr_en;

  // An unknown we fails the equality test, so it reads instead of writing.
  assign wr_en = (we == 1'b1) && !reset;

  always_comb begin
    q_d = mem_q[addr];
    if (we == 1'b1) begin
      q_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_memory.sv
// Directed and randomized checks of the memory block against a sparse reference model,
// with expected read data queued at drive time and popped after each sampling edge.
module tb_memory;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data  = '0;
  logic [AW-1:0] addr  = '0;
  logic          we    = 1'b0;
  logic [DW-1:0] q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .addr  (addr),
    .we    (we),
    .q     (q)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    if (a == 16'h0001) return 16'hB024;
    if (a == 16'h0002) return 16'hB0C3;
    return 16'h0000;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: q=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: no expected value queued", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, q, e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_op(input string tag, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we   = w;
    addr = a;
    data = d;
    if (w) begin
      model_mem[a] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model_rd(a));
    end
    @(posedge clk);
    #1;
    check_sb(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Power-on reset: q must clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_q", q, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_q", q, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Initial image and write-through.
    drive_op("rd_init_1",   1'b0, 16'h0001, 16'h0000);
    drive_op("rd_init_2",   1'b0, 16'h0002, 16'h0000);
    drive_op("rd_init_0",   1'b0, 16'h0000, 16'h0000);
    drive_op("rd_init_4",   1'b0, 16'h0004, 16'h0000);
    drive_op("wr_thru_3",   1'b1, 16'h0003, 16'hBC48);
    drive_op("persist_2",   1'b0, 16'h0002, 16'h0000);
    drive_op("persist_3",   1'b0, 16'h0003, 16'h0000);

    // Output must hold while inputs move between edges.
    drive_op("rd_before_hold", 1'b0, 16'h0001, 16'h0000);
    @(negedge clk);
    we   = 1'b1;
    addr = 16'h0002;
    data = 16'h7777;
    #1;
    check("hold_between_edges", q, 16'hB024);
    we = 1'b0;

    // Reset mid-operation: q clears at once and writes are dropped.
    drive_op("wr_before_rst", 1'b1, 16'h0005, 16'h5555);
    @(negedge clk);
    reset = 1'b1;
    we    = 1'b1;
    addr  = 16'h0003;
    data  = 16'h1234;
    #1;
    check("reset_mid_q", q, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_blocks_wr_q", q, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    we    = 1'b0;
    drive_op("post_rst_rd_3", 1'b0, 16'h0003, 16'h0000);
    drive_op("post_rst_rd_5", 1'b0, 16'h0005, 16'h0000);

    // Address extremes on consecutive edges, then alias probes.
    drive_op("wr_top",      1'b1, 16'hFFFF, 16'hFFFF);
    drive_op("wr_bottom",   1'b1, 16'h0000, 16'hA5A5);
    drive_op("rd_top",      1'b0, 16'hFFFF, 16'h0000);
    drive_op("rd_bottom",   1'b0, 16'h0000, 16'hA5A5);
    drive_op("rd_7fff",     1'b0, 16'h7FFF, 16'h0000);
    drive_op("rd_8000",     1'b0, 16'h8000, 16'h0000);
    drive_op("rd_1_intact", 1'b0, 16'h0001, 16'h0000);

    // Back-to-back writes then immediate reads of the same words.
    drive_op("b2b_wr_10",   1'b1, 16'h0010, 16'h1111);
    drive_op("b2b_wr_11",   1'b1, 16'h0011, 16'h2222);
    drive_op("b2b_rd_11",   1'b0, 16'h0011, 16'h0000);
    drive_op("b2b_rd_10",   1'b0, 16'h0010, 16'h0000);

    // Randomized traffic over a small window so reads often hit written words.
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = 16'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : 16'hFFF8 + $urandom_range(0, 7));
      drive_op("rand_op", 1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 16'hFFFF)));
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
